// File: rtl/mmio_rsel_pipe.sv
// Memory-stage load select (BIOS / DMEM / MMIO) with cycle/instruction counters and sticky event flags.
// Optional feature: define MMIO_EVT_RDCLR_EN to make an event-flag read clear that flag.
module mmio_rsel_pipe #(
    parameter int CNT_WIDTH = 32,
    parameter int NUM_EVT   = 4,
    parameter int BTN_W     = 3,
    parameter int SW_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [31:0]          addr,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          bios_doutb,
    input  logic [31:0]          dmem_douta,
    input  logic                 trmt_full,
    input  logic                 recv_empty,
    input  logic [7:0]           recv_data,
    input  logic                 buttons_empty,
    input  logic [BTN_W-1:0]     buttons,
    input  logic [SW_W-1:0]      switches,
    input  logic                 inst_retire,
    input  logic [NUM_EVT-1:0]   evt,
    output logic [31:0]          dout
);

    typedef enum logic [1:0] {
        SEL_DMEM,
        SEL_BIOS,
        SEL_MMIO
    } sel_t;

    sel_t                 region;
    sel_t                 sel;
    logic [31:0]          mmio_word;
    logic [31:0]          captured;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] inst_cnt;
    logic [NUM_EVT-1:0]   evt_flag;
    logic [15:0]          evt_flag_ext;
    logic                 rd_accept;
    logic                 cnt_clr;
    logic                 mmio_page_ok;
    logic                 evt_hit;

    assign rd_accept    = rd_en & ~stall;
    assign cnt_clr      = wr_en & ~stall & (addr == 32'h8000_0018);
    assign mmio_page_ok = (addr[29:8] == 22'd0);
    assign evt_hit      = mmio_page_ok & (addr[7:6] == 2'b01);
    // Padding to 16 lets addr[5:2] index directly; flags beyond NUM_EVT read as 0.
    assign evt_flag_ext = 16'(evt_flag);

    always_comb begin
        case (addr[31:30])
            2'b01:   region = SEL_BIOS;
            2'b10:   region = SEL_MMIO;
            default: region = SEL_DMEM;
        endcase
    end

    always_comb begin
        mmio_word = 32'd0;
        if (mmio_page_ok) begin
            case (addr[7:2])
                6'h00:   mmio_word = {30'd0, ~recv_empty, ~trmt_full};
                6'h01:   mmio_word = {24'd0, recv_data};
                6'h04:   mmio_word = 32'(cycle_cnt);
                6'h05:   mmio_word = 32'(inst_cnt);
                6'h08:   mmio_word = {31'd0, buttons_empty};
                6'h09:   mmio_word = 32'(buttons);
                6'h0A:   mmio_word = 32'(switches);
                default: begin
                    if (evt_hit) begin
                        mmio_word = {31'd0, evt_flag_ext[addr[5:2]]};
                    end
                end
            endcase
        end
    end

    // Select and MMIO word line up with the one-cycle BRAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= SEL_MMIO;
            captured <= 32'd0;
        end else if (rd_accept) begin
            sel <= region;
            if (region == SEL_MMIO) begin
                captured <= mmio_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (inst_retire) begin
                inst_cnt <= inst_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef MMIO_EVT_RDCLR_EN
    logic [NUM_EVT-1:0] rd_clr;

    always_comb begin
        rd_clr = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            rd_clr[i] = rd_accept && (region == SEL_MMIO) && evt_hit && (addr[5:2] == 4'(i));
        end
    end

    // A new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_flag <= '0;
        end else begin
            evt_flag <= (evt_flag & ~rd_clr) | evt;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_flag <= '0;
        end else begin
            evt_flag <= evt_flag | evt;
        end
    end
`endif

    always_comb begin
        case (sel)
            SEL_BIOS: dout = bios_doutb;
            SEL_DMEM: dout = dmem_douta;
            default:  dout = captured;
        endcase
    end

endmodule

// File: tb/tb_mmio_rsel_pipe.sv
// Self-checking bench for mmio_rsel_pipe: directed literal checks plus randomized traffic against a behavioural model.
// Two instances run side by side: default counter width and CNT_WIDTH = 4 for wrap coverage.
module tb_mmio_rsel_pipe;

    localparam int NUM_EVT = 4;
    localparam int BTN_W   = 3;
    localparam int SW_W    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               stall;
    logic [31:0]        addr;
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        bios_doutb;
    logic [31:0]        dmem_douta;
    logic               trmt_full;
    logic               recv_empty;
    logic [7:0]         recv_data;
    logic               buttons_empty;
    logic [BTN_W-1:0]   buttons;
    logic [SW_W-1:0]    switches;
    logic               inst_retire;
    logic [NUM_EVT-1:0] evt;
    logic [31:0]        dout;
    logic [31:0]        dout4;

    mmio_rsel_pipe #(.CNT_WIDTH(32), .NUM_EVT(NUM_EVT), .BTN_W(BTN_W), .SW_W(SW_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .bios_doutb(bios_doutb), .dmem_douta(dmem_douta), .trmt_full(trmt_full),
        .recv_empty(recv_empty), .recv_data(recv_data), .buttons_empty(buttons_empty),
        .buttons(buttons), .switches(switches), .inst_retire(inst_retire), .evt(evt),
        .dout(dout)
    );

    mmio_rsel_pipe #(.CNT_WIDTH(4), .NUM_EVT(NUM_EVT), .BTN_W(BTN_W), .SW_W(SW_W)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .bios_doutb(bios_doutb), .dmem_douta(dmem_douta), .trmt_full(trmt_full),
        .recv_empty(recv_empty), .recv_data(recv_data), .buttons_empty(buttons_empty),
        .buttons(buttons), .switches(switches), .inst_retire(inst_retire), .evt(evt),
        .dout(dout4)
    );

    int checks = 0;
    int passes = 0;

    // Behavioural model: raw event counts since reset/clear, flag bits, last accepted read.
    longint unsigned mCyc = 0;
    longint unsigned mIns = 0;
    logic [15:0]     mFlags = 16'd0;
    int              mRegion = 2;
    logic [31:0]     mWord32 = 32'd0;
    logic [31:0]     mWord4 = 32'd0;
    bit              modelValid = 1'b0;
    int              mIdx;

    function automatic int evtIndex(logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (wa >= 32'h8000_0040 && wa < 32'h8000_0080) return int'((wa - 32'h8000_0040) / 4);
        return -1;
    endfunction

    function automatic logic [31:0] mmioModel(logic [31:0] a, int w);
        longint unsigned mask;
        logic [31:0]     wa;
        int              i;
        mask = (w >= 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        wa = a & 32'hFFFF_FFFC;
        i = evtIndex(a);
        if (wa == 32'h8000_0000) return {30'd0, !recv_empty, !trmt_full};
        if (wa == 32'h8000_0004) return {24'd0, recv_data};
        if (wa == 32'h8000_0010) return 32'(mCyc & mask);
        if (wa == 32'h8000_0014) return 32'(mIns & mask);
        if (wa == 32'h8000_0020) return {31'd0, buttons_empty};
        if (wa == 32'h8000_0024) return 32'(buttons);
        if (wa == 32'h8000_0028) return 32'(switches);
        if (i >= 0 && i < NUM_EVT) return {31'd0, mFlags[i]};
        return 32'd0;
    endfunction

    function automatic logic [31:0] expDout(logic [31:0] word);
        if (mRegion == 1) return bios_doutb;
        if (mRegion == 0) return dmem_douta;
        return word;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mCyc = 0;
            mIns = 0;
            mFlags = 16'd0;
            mRegion = 2;
            mWord32 = 32'd0;
            mWord4 = 32'd0;
            modelValid = 1'b1;
        end else begin
            if (rd_en && !stall) begin
                mRegion = (addr[31:30] == 2'b01) ? 1 : (addr[31:30] == 2'b10) ? 2 : 0;
                if (mRegion == 2) begin
                    mWord32 = mmioModel(addr, 32);
                    mWord4  = mmioModel(addr, 4);
`ifdef MMIO_EVT_RDCLR_EN
                    mIdx = evtIndex(addr);
                    if (mIdx >= 0 && mIdx < NUM_EVT) mFlags[mIdx] = 1'b0;
`endif
                end
            end
            mFlags = mFlags | 16'(evt);
            if (wr_en && !stall && addr == 32'h8000_0018) begin
                mCyc = 0;
                mIns = 0;
            end else begin
                mCyc++;
                if (inst_retire) mIns++;
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checks++;
            if (dout === expDout(mWord32)) passes++;
            else $display("[TB] FAIL model_dout: got 0x%08h, expected 0x%08h at %0t", dout, expDout(mWord32), $time);
            checks++;
            if (dout4 === expDout(mWord4)) passes++;
            else $display("[TB] FAIL model_dout_w4: got 0x%08h, expected 0x%08h at %0t", dout4, expDout(mWord4), $time);
        end
    end

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic applyStimulus(bit rd, bit wr, logic [31:0] a, bit ret, logic [NUM_EVT-1:0] ev);
        rd_en = rd;
        wr_en = wr;
        addr = a;
        inst_retire = ret;
        evt = ev;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        inst_retire = 1'b0;
        evt = '0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; addr = 32'd0; rd_en = 1'b0; wr_en = 1'b0;
        bios_doutb = 32'd0; dmem_douta = 32'd0; trmt_full = 1'b0; recv_empty = 1'b1;
        recv_data = 8'd0; buttons_empty = 1'b1; buttons = '0; switches = '0;
        inst_retire = 1'b0; evt = '0;

        repeat (3) applyStimulus(0, 0, 32'd0, 0, '0);
        checkOutput("reset_dout", dout, 32'd0);
        checkOutput("reset_dout_w4", dout4, 32'd0);
        rst = 1'b0;

        dmem_douta = 32'hDEAD_BEEF;
        applyStimulus(1, 0, 32'h0000_1000, 0, '0);
        checkOutput("dmem_read", dout, 32'hDEAD_BEEF);
        bios_doutb = 32'h1234_5678;
        applyStimulus(1, 0, 32'h4000_0000, 0, '0);
        checkOutput("bios_read", dout, 32'h1234_5678);

        recv_empty = 1'b0; trmt_full = 1'b1; recv_data = 8'hA5;
        applyStimulus(1, 0, 32'h8000_0000, 0, '0);
        checkOutput("uart_status", dout, 32'h0000_0002);
        applyStimulus(1, 0, 32'h8000_0004, 0, '0);
        checkOutput("uart_data", dout, 32'h0000_00A5);
        applyStimulus(1, 0, 32'h8000_0030, 0, '0);
        checkOutput("unmapped", dout, 32'd0);

        applyStimulus(0, 1, 32'h8000_0018, 0, '0);
        applyStimulus(1, 0, 32'h8000_0014, 0, '0);
        checkOutput("inst_after_clear", dout, 32'd0);
        applyStimulus(1, 0, 32'h8000_0010, 0, '0);
        checkOutput("cycle_after_clear", dout, 32'd1);
        repeat (14) applyStimulus(0, 0, 32'd0, 0, '0);
        applyStimulus(1, 0, 32'h8000_0010, 0, '0);
        checkOutput("cycle_16", dout, 32'd16);
        checkOutput("cycle_wrap_w4", dout4, 32'd0);

        applyStimulus(0, 1, 32'h8000_0018, 0, '0);
        for (int k = 0; k < 100; k++) applyStimulus(0, 0, 32'd0, (k < 40), '0);
        applyStimulus(1, 0, 32'h8000_0010, 0, '0);
        checkOutput("cycle_100", dout, 32'd100);
        checkOutput("cycle_100_w4", dout4, 32'd4);
        applyStimulus(1, 0, 32'h8000_0014, 0, '0);
        checkOutput("inst_40", dout, 32'd40);
        checkOutput("inst_40_w4", dout4, 32'd8);

        applyStimulus(0, 0, 32'd0, 0, 4'b0100);
        applyStimulus(1, 0, 32'h8000_0048, 0, '0);
        checkOutput("evt2_first", dout, 32'd1);
        applyStimulus(1, 0, 32'h8000_0048, 0, '0);
`ifdef MMIO_EVT_RDCLR_EN
        checkOutput("evt2_second", dout, 32'd0);
`else
        checkOutput("evt2_second", dout, 32'd1);
`endif
        applyStimulus(0, 0, 32'd0, 0, 4'b0100);
        applyStimulus(1, 0, 32'h8000_0048, 0, 4'b0100);
        checkOutput("evt2_set_during_read", dout, 32'd1);
        applyStimulus(1, 0, 32'h8000_0048, 0, '0);
        checkOutput("evt2_set_wins", dout, 32'd1);

        buttons = 3'b101;
        applyStimulus(0, 1, 32'h8000_0018, 0, '0);
        applyStimulus(1, 0, 32'h8000_0024, 0, '0);
        checkOutput("buttons_read", dout, 32'd5);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 32'h8000_0018, 0, '0);
            checkOutput("stall_hold", dout, 32'd5);
        end
        stall = 1'b0;
        applyStimulus(1, 0, 32'h8000_0010, 0, '0);
        checkOutput("stall_no_clear", dout, 32'd6);

        applyStimulus(0, 1, 32'h8000_0018, 0, '0);
        for (int k = 0; k < 50; k++) applyStimulus(0, 0, 32'd0, 1, (k == 0) ? 4'b0100 : 4'b0000);
        applyStimulus(1, 0, 32'h8000_0010, 0, '0);
        checkOutput("cycle_50", dout, 32'd50);
        checkOutput("cycle_50_w4", dout4, 32'd2);
        rst = 1'b1;
        applyStimulus(1, 0, 32'h8000_0014, 1, '0);
        checkOutput("rst_dout", dout, 32'd0);
        rst = 1'b0;
        applyStimulus(1, 0, 32'h8000_0010, 0, '0);
        checkOutput("rst_cycle", dout, 32'd0);
        applyStimulus(1, 0, 32'h8000_0014, 0, '0);
        checkOutput("rst_inst", dout, 32'd0);
        applyStimulus(1, 0, 32'h8000_0048, 0, '0);
        checkOutput("rst_flag", dout, 32'd0);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] addrTable [17];
            logic [31:0] a;
            addrTable = '{32'h0000_1000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0004,
                          32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_0020,
                          32'h8000_0024, 32'h8000_0028, 32'h8000_0040, 32'h8000_0044,
                          32'h8000_0048, 32'h8000_004C, 32'h8000_0050, 32'h8000_0030,
                          32'h8000_0110};
            a = ($urandom_range(0, 9) == 0) ? $urandom() : addrTable[$urandom_range(0, 16)];
            rst = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 4) == 0);
            bios_doutb = $urandom();
            dmem_douta = $urandom();
            trmt_full = 1'($urandom());
            recv_empty = 1'($urandom());
            recv_data = 8'($urandom());
            buttons_empty = 1'($urandom());
            buttons = BTN_W'($urandom());
            switches = SW_W'($urandom());
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, a,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0) ? NUM_EVT'($urandom()) : '0);
        end
        rst = 1'b0;
        stall = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
